// File: rtl/arbitro_mem.sv
// Arbiter that lets the fetch and data paths of the multicycle core share one
// variable-latency single-port memory, with a watchdog that ends hung accesses.
module arbitro_mem #(
  parameter int ANCHO_DIR    = 32,
  parameter int TIMEOUT      = 15,
  parameter int MAX_SEGUIDOS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ANCHO_DIR-1:0] if_dir,
  output logic                 if_ack,
  output logic [31:0]          if_dato,
  input  logic                 dat_req,
  input  logic                 dat_esc,
  input  logic [ANCHO_DIR-1:0] dat_dir,
  input  logic [31:0]          dat_wdata,
  input  logic [3:0]           dat_mascara,
  output logic                 dat_ack,
  output logic [31:0]          dat_rdata,
  output logic                 mem_sel,
  output logic                 mem_esc,
  output logic [ANCHO_DIR-1:0] mem_dir,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_mascara,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_listo,
  output logic                 error
);

  localparam int SW = $clog2(MAX_SEGUIDOS + 1);

  typedef enum logic [1:0] {LIBRE, ACCESO, FIN} estado_t;

  estado_t       estado;
  logic [7:0]    cnt_to;
  logic [SW-1:0] seguidos;
  logic          es_dato;   // granted requester: 1 = data path, 0 = fetch

  // Data wins ties until it has been granted MAX_SEGUIDOS times in a row
  // over a waiting fetch.
  logic fetch_forzado, grant_dato, grant_fetch;
  assign fetch_forzado = if_req && (seguidos == SW'(MAX_SEGUIDOS));
  assign grant_dato    = dat_req && !fetch_forzado;
  assign grant_fetch   = if_req && !grant_dato;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= LIBRE;
      cnt_to      <= '0;
      seguidos    <= '0;
      es_dato     <= 1'b0;
      if_ack      <= 1'b0;
      if_dato     <= '0;
      dat_ack     <= 1'b0;
      dat_rdata   <= '0;
      mem_sel     <= 1'b0;
      mem_esc     <= 1'b0;
      mem_dir     <= '0;
      mem_wdata   <= '0;
      mem_mascara <= '0;
      error       <= 1'b0;
    end else begin
      case (estado)
        LIBRE: begin
          if (grant_dato) begin
            es_dato     <= 1'b1;
            mem_esc     <= dat_esc;
            mem_dir     <= dat_dir;
            mem_wdata   <= dat_wdata;
            mem_mascara <= dat_mascara;
            mem_sel     <= 1'b1;
            estado      <= ACCESO;
            if (if_req) seguidos <= seguidos + SW'(1);
          end else if (grant_fetch) begin
            es_dato     <= 1'b0;
            mem_esc     <= 1'b0;
            mem_dir     <= if_dir;
            mem_wdata   <= '0;
            mem_mascara <= '0;
            mem_sel     <= 1'b1;
            estado      <= ACCESO;
            seguidos    <= '0;
          end
        end
        ACCESO: begin
          cnt_to <= cnt_to + 8'd1;
          // mem_listo wins over the watchdog when both land on the same cycle
          if (mem_listo) begin
            mem_sel <= 1'b0;
            estado  <= FIN;
            if (es_dato) begin
              dat_ack <= 1'b1;
              if (!mem_esc) dat_rdata <= mem_rdata;
            end else begin
              if_ack  <= 1'b1;
              if_dato <= mem_rdata;
            end
          end else if (cnt_to == 8'(TIMEOUT - 1)) begin
            mem_sel <= 1'b0;
            estado  <= FIN;
            error   <= 1'b1;
            if (es_dato) begin
              dat_ack <= 1'b1;
              if (!mem_esc) dat_rdata <= '0;
            end else begin
              if_ack  <= 1'b1;
              if_dato <= '0;
            end
          end
        end
        FIN: begin
          if_ack  <= 1'b0;
          dat_ack <= 1'b0;
          error   <= 1'b0;
          cnt_to  <= '0;
          estado  <= LIBRE;
        end
        default: estado <= LIBRE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mem.sv
// Bench for arbitro_mem: directed vector table, corner-case sequences and
// randomized rounds checked by a transaction-level arbitration/memory model.
module tb_arbitro_mem;
  localparam int TO   = 15;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, dat_req = 1'b0, dat_esc = 1'b0;
  logic [31:0] if_dir = '0, dat_dir = '0, dat_wdata = '0;
  logic [3:0]  dat_mascara = '0;
  logic        if_ack, dat_ack, mem_sel, mem_esc, error;
  logic [31:0] if_dato, dat_rdata, mem_dir, mem_wdata;
  logic [3:0]  mem_mascara;
  logic [31:0] mem_rdata = '0;
  logic        mem_listo = 1'b0;

  arbitro_mem #(.ANCHO_DIR(32), .TIMEOUT(TO), .MAX_SEGUIDOS(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_dir(if_dir), .if_ack(if_ack), .if_dato(if_dato),
    .dat_req(dat_req), .dat_esc(dat_esc), .dat_dir(dat_dir), .dat_wdata(dat_wdata),
    .dat_mascara(dat_mascara), .dat_ack(dat_ack), .dat_rdata(dat_rdata),
    .mem_sel(mem_sel), .mem_esc(mem_esc), .mem_dir(mem_dir), .mem_wdata(mem_wdata),
    .mem_mascara(mem_mascara), .mem_rdata(mem_rdata), .mem_listo(mem_listo),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fetch;
    bit          esc;
    logic [31:0] dir;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          lat;    // ACCESO cycle in which mem_listo rises; 0 = never
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          fetch;
    bit          esc;
    logic [31:0] dir;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_out;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  txn_t        exp_q[$], f_todo[$], d_todo[$];
  txn_t        cur;
  bit          cur_v = 0;
  int          sel_cnt = 0, last_cyc = 0, streak_m = 0;
  logic        last_err = 1'b0;
  bit          if_seen = 0, dat_seen = 0;
  logic [31:0] exp_if = '0, exp_dat = '0, ack_log = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder plus scoreboard: each grant must match the next expected
  // transaction, and its ack/data/error follow from the latency rules.
  always @(negedge clk) begin
    bit ok;
    int ecyc;
    if (!reset) begin
      cur_v = 0; sel_cnt = 0; mem_listo = 1'b0; exp_if = '0; exp_dat = '0;
    end else begin
      if (mem_sel) begin
        if (!cur_v) begin
          if (exp_q.size() == 0) chk("spurious_sel", 32'(mem_sel), 32'd0);
          else begin cur = exp_q.pop_front(); cur_v = 1; sel_cnt = 0; end
        end
        if (cur_v) begin
          sel_cnt++;
          chk("mem_dir", mem_dir, cur.dir);
          chk("mem_esc", 32'(mem_esc), 32'(cur.fetch ? 1'b0 : cur.esc));
          chk("mem_mascara", 32'(mem_mascara), 32'(cur.fetch ? 4'h0 : cur.mask));
          if (!cur.fetch && cur.esc) chk("mem_wdata", mem_wdata, cur.wdata);
          chk("ack_in_acc", 32'({if_ack, dat_ack, error}), 32'd0);
          mem_listo = (sel_cnt == cur.lat);
          mem_rdata = mem_listo ? cur.rdata : $urandom;
        end else mem_listo = 1'b0;
      end else begin
        mem_listo = 1'b0;
        if (cur_v) begin
          ok   = (cur.lat != 0) && (cur.lat <= TO);
          ecyc = ok ? cur.lat : TO;
          chk("sel_cycles", 32'(sel_cnt), 32'(ecyc));
          last_cyc = sel_cnt;
          chk("if_ack", 32'(if_ack), 32'(cur.fetch));
          chk("dat_ack", 32'(dat_ack), 32'(!cur.fetch));
          chk("error", 32'(error), 32'(!ok));
          last_err = error;
          if (cur.fetch) exp_if = ok ? cur.rdata : 32'h0;
          else if (!cur.esc) exp_dat = ok ? cur.rdata : 32'h0;
          ack_log = {ack_log[30:0], !cur.fetch};
          if (cur.fetch) if_seen = 1; else dat_seen = 1;
          cur_v = 0;
        end else chk("idle_ack", 32'({if_ack, dat_ack, error}), 32'd0);
      end
      chk("if_dato", if_dato, exp_if);
      chk("dat_rdata", dat_rdata, exp_dat);
    end
  end

  task automatic drive();
    if_req  = (f_todo.size() > 0);
    if (if_req) if_dir = f_todo[0].dir;
    dat_req = (d_todo.size() > 0);
    if (dat_req) begin
      dat_esc = d_todo[0].esc; dat_dir = d_todo[0].dir;
      dat_wdata = d_todo[0].wdata; dat_mascara = d_todo[0].mask;
    end
  endtask

  // Raises all queued requests together; data holds req across back-to-back
  // transactions. Expected grant order comes from the priority rule.
  task automatic run_round();
    int nf = f_todo.size(), nd = d_todo.size(), di = 0, cyc = 0;
    while (nf > 0 || di < nd) begin
      if (nf > 0 && di < nd) begin
        if (streak_m == MAXS) begin exp_q.push_back(f_todo[0]); nf = 0; streak_m = 0; end
        else begin exp_q.push_back(d_todo[di]); di++; streak_m++; end
      end else if (di < nd) begin
        exp_q.push_back(d_todo[di]); di++;
      end else begin
        exp_q.push_back(f_todo[0]); nf = 0; streak_m = 0;
      end
    end
    if_seen = 0; dat_seen = 0;
    while ((f_todo.size() > 0 || d_todo.size() > 0) && cyc < 60 * (nd + 2)) begin
      drive();
      @(posedge clk); #1; cyc++;
      if (if_seen) begin if_seen = 0; if (f_todo.size() > 0) f_todo.delete(0); end
      if (dat_seen) begin dat_seen = 0; if (d_todo.size() > 0) d_todo.delete(0); end
    end
    if (f_todo.size() > 0 || d_todo.size() > 0) begin
      chk("round_timeout", 32'(f_todo.size() + d_todo.size()), 32'd0);
      f_todo.delete(); d_todo.delete(); exp_q.delete();
    end
    if_req = 1'b0; dat_req = 1'b0;
  endtask

  function automatic txn_t mk(bit f, bit e, logic [31:0] d, logic [31:0] w,
                              logic [3:0] m, int l, logic [31:0] r);
    txn_t t;
    t.fetch = f; t.esc = e; t.dir = d; t.wdata = w; t.mask = m; t.lat = l; t.rdata = r;
    return t;
  endfunction

  function automatic txn_t rand_txn(bit f);
    txn_t t;
    t = mk(f, f ? 1'b0 : 1'($urandom % 2), $urandom & 32'hFFFF_FFFC, $urandom,
           4'($urandom), $urandom_range(1, 5), $urandom);
    if (!t.esc && ($urandom % 6 == 0))
      case ($urandom % 3)
        0: t.lat = 0;
        1: t.lat = TO;
        default: t.lat = TO + 1;
      endcase
    return t;
  endfunction

  task automatic wait_sel();
    for (int c = 0; c < 10 && !mem_sel; c++) begin @(posedge clk); #1; end
    chk("sel_rise", 32'(mem_sel), 32'd1);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 0, 32'h0000_0004, 32'h0, 4'h0, 2,      32'h0000_0293, 32'h0000_0293, 0, 2};
    vt[1] = '{0, 1, 32'h0000_0100, 32'hCAFE_BABE, 4'h3, 1, 32'hDEAD_0001, 32'h0000_0000, 0, 1};
    vt[2] = '{0, 0, 32'h0000_0200, 32'h0, 4'h0, 3,      32'h1234_5678, 32'h1234_5678, 0, 3};
    vt[3] = '{0, 1, 32'h0000_0104, 32'h1111_2222, 4'hF, 2, 32'hDEAD_0002, 32'h1234_5678, 0, 2};
    vt[4] = '{1, 0, 32'h0000_0008, 32'h0, 4'h0, 0,      32'h0000_0055, 32'h0000_0000, 1, 15};
    vt[5] = '{1, 0, 32'h0000_000C, 32'h0, 4'h0, 15,     32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 15};
    vt[6] = '{0, 0, 32'h0000_0300, 32'h0, 4'h0, 16,     32'h7777_7777, 32'h0000_0000, 1, 15};
    vt[7] = '{0, 0, 32'h0000_0304, 32'h0, 4'h0, 1,      32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 32'({mem_sel, mem_esc, if_ack, dat_ack, error, mem_mascara}), 32'd0);
    chk("reset_if_dato", if_dato, 32'd0);
    chk("reset_dat_rdata", dat_rdata, 32'd0);
    chk("reset_mem_dir", mem_dir, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      txn_t t;
      t = mk(vt[i].fetch, vt[i].esc, vt[i].dir, vt[i].wdata, vt[i].mask, vt[i].lat, vt[i].rdata);
      if (t.fetch) f_todo.push_back(t); else d_todo.push_back(t);
      last_err = 1'bx; last_cyc = -1;
      run_round();
      chk($sformatf("vec%0d_out", i), vt[i].fetch ? if_dato : dat_rdata, vt[i].exp_out);
      chk($sformatf("vec%0d_err", i), 32'(last_err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_cyc", i), 32'(last_cyc), 32'(vt[i].exp_cyc));
    end

    // simultaneous requests: data first, then fetch
    ack_log = '0;
    f_todo.push_back(mk(1, 0, 32'h0000_0010, 0, 0, 1, 32'h0000_AAAA));
    d_todo.push_back(mk(0, 0, 32'h0000_0400, 0, 0, 2, 32'h0000_BBBB));
    run_round();
    chk("simul_order", ack_log & 32'h3, 32'b10);

    // starvation guard: four data grants, forced fetch, then data resumes
    ack_log = '0;
    f_todo.push_back(mk(1, 0, 32'h0000_0020, 0, 0, 1, 32'h0000_0F0F));
    for (int i = 0; i < 6; i++)
      d_todo.push_back(mk(0, 0, 32'h0000_0500 + 32'(i * 4), 0, 0, 1, 32'h0000_5000 + 32'(i)));
    run_round();
    chk("starve_order", ack_log & 32'h7F, 32'b1111011);

    // address change and req drop mid-access must not disturb the access
    exp_q.push_back(mk(1, 0, 32'h0000_0080, 0, 0, 4, 32'h0000_0077));
    if_seen = 0; if_req = 1'b1; if_dir = 32'h0000_0080;
    wait_sel();
    if_req = 1'b0; if_dir = 32'hFFFF_FFF0;
    for (int c = 0; c < 20 && !if_seen; c++) begin @(posedge clk); #1; end
    chk("drop_req_ack", 32'(if_seen), 32'd1);
    chk("drop_req_dato", if_dato, 32'h0000_0077);
    if_seen = 0;
    @(posedge clk); #1;

    // reset during ACCESO aborts without an ack
    exp_q.push_back(mk(1, 0, 32'h0000_0040, 0, 0, 0, 32'h0));
    if_req = 1'b1; if_dir = 32'h0000_0040;
    wait_sel();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_sel", 32'(mem_sel), 32'd0);
    chk("rst_ack", 32'({if_ack, dat_ack, error}), 32'd0);
    if_req = 1'b0; exp_q.delete(); streak_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dato", if_dato, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    f_todo.push_back(mk(1, 0, 32'h0000_0044, 0, 0, 2, 32'h0000_1111));
    run_round();
    chk("post_rst_fetch", if_dato, 32'h0000_1111);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit hf;
      int nd;
      hf = 1'($urandom % 2);
      nd = $urandom_range(0, 5);
      if (!hf && nd == 0) nd = 1;
      if (hf) f_todo.push_back(rand_txn(1));
      for (int i = 0; i < nd; i++) d_todo.push_back(rand_txn(0));
      run_round();
    end
    chk("queue_drained", 32'(exp_q.size() + 32'(cur_v)), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
